// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared definitions for CPU-bus masters.
//   dma_state_e  - OAM DMA sequencer state encoding (3 bits)
//   ADDR_OAMDMA  - $4014, CPU write here starts an OAM DMA
//   ADDR_OAMDATA - $2004, PPU OAMDATA register
package nes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: OAM DMA sequencer for the $4014 register (CPU clock domain).
// A CPU write of page P to DMA_REG_ADDR halts the CPU, then the block masters
// the bus and performs XFER_LEN read/write pairs: read {P,i}, write the byte
// to OAM_DATA_ADDR. The top level muxes the bus onto the o_dma_* outputs
// while o_dma_act is high.
//
// Optional build macro OAMDMA_ALIGN_EN: when defined, a parity flop tracks
// CPU cycle parity and an extra ALIGN cycle is inserted when the HALT cycle
// is odd (513/514-cycle stall). When undefined the stall is always 513.
//
// Ports:
//   i_cpu_clk, i_cpu_rstn        clock, async active-low reset
//   i_bus_addr/i_bus_wn/i_bus_wdata  CPU-driven bus (trigger detection)
//   i_dma_rdata                  read data returned for DMA reads
//   o_dma_act                    DMA owns the bus (mux select)
//   o_dma_addr/o_dma_wn/o_dma_wdata  DMA bus cycle
//   o_cpu_rdy                    0 = CPU halted
//   o_dma_busy                   transfer in progress incl. HALT/ALIGN
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
  parameter int          XFER_LEN      = 256  // power of 2, <= 256
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  input  logic [7:0]  i_dma_rdata,
  output logic        o_dma_act,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata,
  output logic        o_cpu_rdy,
  output logic        o_dma_busy
);

  localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

  dma_state_e r_state, state_nxt;
  logic [7:0] r_page;
  logic [8:0] r_count;
  logic [7:0] r_latch;
  logic       trig;

  // The CPU is halted whenever we are not idle, so a $4014 write can only
  // come from the CPU while idle; DMA writes never target DMA_REG_ADDR.
  assign trig = (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;

`ifdef OAMDMA_ALIGN_EN
  logic r_odd;

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) r_odd <= 1'b0;
    else             r_odd <= ~r_odd;
  end
`endif

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_state <= ST_IDLE;
      r_page  <= '0;
      r_count <= '0;
      r_latch <= '0;
    end else begin
      r_state <= state_nxt;
      if (r_state == ST_IDLE && trig) begin
        r_page  <= i_bus_wdata;
        r_count <= '0;
      end
      if (r_state == ST_READ)  r_latch <= i_dma_rdata;
      if (r_state == ST_WRITE) r_count <= r_count + 9'd1;
    end
  end

  always_comb begin
    state_nxt   = r_state;
    o_dma_act   = 1'b0;
    o_dma_addr  = '0;
    o_dma_wn    = 1'b1;
    o_dma_wdata = '0;
    o_cpu_rdy   = 1'b0;
    o_dma_busy  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_cpu_rdy  = 1'b1;
        o_dma_busy = 1'b0;
        if (trig) state_nxt = ST_HALT;
      end
      ST_HALT: begin
`ifdef OAMDMA_ALIGN_EN
        state_nxt = r_odd ? ST_ALIGN : ST_READ;
`else
        state_nxt = ST_READ;
`endif
      end
`ifdef OAMDMA_ALIGN_EN
      ST_ALIGN: state_nxt = ST_READ;
`endif
      ST_READ: begin
        o_dma_act  = 1'b1;
        // Address wraps inside the page; the page byte never increments.
        o_dma_addr = {r_page, r_count[7:0]};
        state_nxt  = ST_WRITE;
      end
      ST_WRITE: begin
        o_dma_act   = 1'b1;
        o_dma_addr  = OAM_DATA_ADDR;
        o_dma_wn    = 1'b0;
        o_dma_wdata = r_latch;
        state_nxt   = (r_count == LAST_IDX) ? ST_IDLE : ST_READ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  localparam int XFER = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_wn = 1'b1;
  logic [7:0]  bus_wdata = 8'h00;
  logic [7:0]  dma_rdata;
  logic        dma_act;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;
  logic        cpu_rdy;
  logic        dma_busy;

  always #5 clk = ~clk;

  oam_dma_ctrl dut (
    .i_cpu_clk  (clk),
    .i_cpu_rstn (rst_n),
    .i_bus_addr (bus_addr),
    .i_bus_wn   (bus_wn),
    .i_bus_wdata(bus_wdata),
    .i_dma_rdata(dma_rdata),
    .o_dma_act  (dma_act),
    .o_dma_addr (dma_addr),
    .o_dma_wn   (dma_wn),
    .o_dma_wdata(dma_wdata),
    .o_cpu_rdy  (cpu_rdy),
    .o_dma_busy (dma_busy)
  );

  // Behavioural environment: CPU memory, PPU OAM with auto-incrementing OAMADDR
  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];
  logic [7:0] oamaddr;

  assign dma_rdata = mem[dma_addr];

  typedef struct {
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  data;
  } xact_t;

  xact_t exp_q[$];
  int    stall_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    stall_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Clock edges since reset release; CPU cycle parity is cyc[0].
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: compares each DMA bus cycle and each stall length with the queues.
  always @(negedge clk) begin
    xact_t e;
    if (!rst_n) begin
      stall_run = 0;
    end else begin
      if (dma_act) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bus_cycle addr=%0h wn=%0b required=none", dma_addr, dma_wn);
        end else begin
          e = exp_q.pop_front();
          chk("dma_addr", 32'(dma_addr), 32'(e.addr));
          chk("dma_wn", 32'(dma_wn), 32'(e.wn));
          if (!e.wn) chk("dma_wdata", 32'(dma_wdata), 32'(e.data));
        end
        if (!dma_wn && dma_addr == 16'h2004) begin
          oam[oamaddr] = dma_wdata;
          oamaddr      = oamaddr + 8'd1;
        end
      end
      chk("busy_vs_rdy", 32'(dma_busy), 32'(!cpu_rdy));
      if (!cpu_rdy) begin
        stall_run++;
      end else if (stall_run > 0) begin
        if (stall_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_stall actual=%0d required=0", stall_run);
        end else begin
          chk("stall_len", 32'(stall_run), 32'(stall_q.pop_front()));
        end
        stall_run = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_act"},   32'(dma_act),   32'd0);
    chk({tag, "_addr"},  32'(dma_addr),  32'd0);
    chk({tag, "_wn"},    32'(dma_wn),    32'd1);
    chk({tag, "_wdata"}, 32'(dma_wdata), 32'd0);
    chk({tag, "_rdy"},   32'(cpu_rdy),   32'd1);
    chk({tag, "_busy"},  32'(dma_busy),  32'd0);
  endtask

  // Called on a negedge; trigger is sampled on the next posedge, which
  // enters HALT. Expected responses are derived from memory contents.
  task automatic dma_start(input logic [7:0] p, input bit twice, input logic [7:0] p2);
    int stall;
    bit odd_halt;
    odd_halt = ((cyc + 1) % 2) == 1;
    stall = 513;
`ifdef OAMDMA_ALIGN_EN
    if (odd_halt) stall = 514;
`endif
    stall_q.push_back(stall);
    for (int i = 0; i < XFER; i++) begin
      exp_q.push_back('{addr: {p, 8'(i)}, wn: 1'b1, data: 8'h00});
      exp_q.push_back('{addr: 16'h2004, wn: 1'b0, data: mem[{p, 8'(i)}]});
    end
    bus_addr  = 16'h4014;
    bus_wn    = 1'b0;
    bus_wdata = p;
    @(negedge clk);
    if (twice) begin
      bus_wdata = p2;
      @(negedge clk);
    end
    bus_addr  = 16'h0000;
    bus_wn    = 1'b1;
    bus_wdata = 8'h00;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && stall_q.size() == 0 && cpu_rdy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_timeout"}, 32'(n >= 3000), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic align_halt(input int want_odd);
    @(negedge clk);
    while (((cyc + 1) % 2) != want_odd) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      oam[i] = 8'h00;
    end
    oamaddr = 8'h10;

    #1;
    check_reset_outputs("por");
    #13;
    @(negedge clk);
    rst_n = 1'b1;

    // Even HALT cycle, page 02, OAMADDR preset to $10
    align_halt(0);
    dma_start(8'h02, 1'b0, 8'h00);
    wait_done("even");
    for (int i = 0; i < 256; i++)
      chk("oam_content", 32'(oam[8'(8'h10 + i)]), 32'(8'(i) ^ 8'h5A));

    // Odd HALT cycle, same page
    align_halt(1);
    dma_start(8'h02, 1'b0, 8'h00);
    wait_done("odd");

    // Page FF: wraps inside the page only
    align_halt(0);
    dma_start(8'hFF, 1'b0, 8'h00);
    wait_done("pageff");

    // Non-trigger accesses
    @(negedge clk);
    bus_addr = 16'h4013; bus_wn = 1'b0; bus_wdata = 8'h05;
    @(negedge clk);
    chk("no_trig_4013_rdy", 32'(cpu_rdy), 32'd1);
    bus_addr = 16'h4015; bus_wn = 1'b0; bus_wdata = 8'h06;
    @(negedge clk);
    chk("no_trig_4015_rdy", 32'(cpu_rdy), 32'd1);
    bus_addr = 16'h4014; bus_wn = 1'b1; bus_wdata = 8'h07;
    @(negedge clk);
    chk("no_trig_rd4014_rdy", 32'(cpu_rdy), 32'd1);
    bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    @(negedge clk);
    chk("no_trig_busy", 32'(dma_busy), 32'd0);
    chk("no_trig_act", 32'(dma_act), 32'd0);

    // Back-to-back $4014 writes: only the first page is transferred
    dma_start(8'h05, 1'b1, 8'h06);
    wait_done("b2b");

    // Reset after 100 completed read/write pairs
    dma_start(8'h07, 1'b0, 8'h00);
    n = 0;
    while (exp_q.size() > 2 * XFER - 200 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_timeout", 32'(n >= 1000), 32'd0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    stall_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    check_reset_outputs("held_reset");
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rdy", 32'(cpu_rdy), 32'd1);
    dma_start(8'h03, 1'b0, 8'h00);
    wait_done("after_reset");

    // Randomized pages and trigger parities
    for (int t = 0; t < 3; t++) begin
      align_halt(int'($urandom_range(0, 1)));
      dma_start(8'($urandom), 1'b0, 8'h00);
      wait_done("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
